generic_data_bram: RTL and testbench
====================================

Name: generic_data_bram

Overview:
- Simple dual-port, byte-maskable block RAM: one write port, one read port, one clock.
- Generic storage primitive under the data-cache data array. The cache wrapper adds write-to-read forwarding around it.
- Read data is registered: one-cycle latency, and old data is returned on a same-address read-during-write.
- Maps onto FPGA block RAM (M9K-class) with a registered output.

Parameters:
- DATA_WIDTH, 256, word width in bits. Must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 8, address width. DEPTH = 2**ADDR_WIDTH words.

Ports:
- clock  in  1  sole clock; all activity on its rising edge.
- aclr  in  1  reset, synchronous, active-high. Clears the read output register only.
- rden  in  1  read enable.
- rdaddress  in  ADDR_WIDTH  read word address.
- q  out  DATA_WIDTH  registered read data.
- wren  in  1  write enable.
- wraddress  in  ADDR_WIDTH  write word address.
- data  in  DATA_WIDTH  write data.
- byteena_a  in  NBYTES  per-byte write enable. Bit i gates data[8i+7:8i].

Behaviour:
- Storage: DEPTH x DATA_WIDTH array, all words zero at power-up. aclr never modifies array contents.
- Write, at edge t when wren=1: for each i with byteena_a[i]=1, mem[wraddress] byte i takes data byte i.
  - Bytes whose enable is 0 keep their old value.
  - wren=1 with byteena_a=0 is a no-op.
- Read, at edge t when rden=1 and aclr=0: q takes mem[rdaddress] as it was before edge t's write. q is valid after the edge, i.e. 1-cycle latency.
- rden=0: q holds its previous value indefinitely.
- Read-during-write, same address, same edge: q returns OLD data (pre-write contents, all bytes). The new data is visible to a read issued on the next edge.
- Different addresses on the same edge: fully independent, no interaction.
- Reset: aclr=1 at an edge sets q to 0, overriding rden. Writes on that same edge still commit.
- Reset mid-operation: after aclr deasserts, q stays 0 until the next rden=1 edge. No other state exists.
- Addresses: full range 0..DEPTH-1 valid, no wrap or out-of-range cases. No X propagation from unwritten words, because of the zero init.
- No handshakes and no backpressure. Every edge accepts one read and one write.
- Synthesizable as inferred RAM: one write process with per-byte enables, a registered read, and old-data read-during-write semantics.

Decomposition:
- No shared package required. NBYTES is a localparam.
- Natural sub-module: generic_data_bram_lane, an 8-bit-wide, DEPTH-deep simple dual-port lane.
  - Each lane has its own write enable (wren & byteena_a[i]) and shares rden, the addresses and aclr.
  - The top level is a generate loop of NBYTES lanes that concatenates their q outputs.

Test Plan:
- Basic write/read (DATA_WIDTH=256, ADDR_WIDTH=8):
  - Write 0x0123...EF (32 bytes) to address 5 with byteena all-ones.
  - Next cycle, rden at address 5 -> q equals that value one edge later.
- Byte mask:
  - Address 9 holds all 0xAA.
  - Write all 0x55 with byteena=0x0000000F.
  - Read -> bytes 0-3 = 0x55, bytes 4-31 = 0xAA.
- Read-during-write, same address:
  - Address 3 holds 0x11..11.
  - Same edge: write 0x22..22 and read address 3 -> q=0x11..11.
  - Read address 3 again on the next edge -> q=0x22..22.
- Hold, then reset:
  - Read address 5 (q=V), then rden=0 for 4 cycles -> q stays V.
  - Assert aclr one cycle -> q=0.
  - Re-read address 5 -> q=V, showing contents survive reset.
- Independent ports:
  - Write address 0x10 while reading address 0x20 on the same edge -> q = old mem[0x20]. mem[0x10] is updated.
- Power-up: read an unwritten address such as 0xFF -> q=0.

Source files
------------

// File: rtl/generic_data_bram_pkg.sv
// rtl/generic_data_bram_pkg.sv - shared constants and helpers for the byte-lane block RAM
package generic_data_bram_pkg;

    localparam int BYTE_WIDTH = 8;

    // Number of byte lanes needed to cover a word of the given width.
    function automatic int byte_lanes(input int width);
        return width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/generic_data_bram_lane.sv
// rtl/generic_data_bram_lane.sv - one byte-wide simple dual-port RAM lane with registered read
module generic_data_bram_lane
    import generic_data_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  rden,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [BYTE_WIDTH-1:0] q,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic [BYTE_WIDTH-1:0] data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [BYTE_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clock) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
    end

    // Non-blocking update of mem gives old data on a same-address collision.
    always_ff @(posedge clock) begin
        if (aclr) begin
            q <= '0;
        end else if (rden) begin
            q <= mem[rdaddress];
        end
    end

endmodule

// File: rtl/generic_data_bram.sv
// rtl/generic_data_bram.sv - byte-maskable simple dual-port block RAM built from byte lanes
module generic_data_bram
    import generic_data_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             aclr,
    input  logic                             rden,
    input  logic [ADDR_WIDTH-1:0]            rdaddress,
    output logic [DATA_WIDTH-1:0]            q,
    input  logic                             wren,
    input  logic [ADDR_WIDTH-1:0]            wraddress,
    input  logic [DATA_WIDTH-1:0]            data,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteena_a
);

    localparam int NBYTES = byte_lanes(DATA_WIDTH);

    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
        logic lane_wren;

        assign lane_wren = wren & byteena_a[i];

        generic_data_bram_lane #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_lane (
            .clock     (clock),
            .aclr      (aclr),
            .rden      (rden),
            .rdaddress (rdaddress),
            .q         (q[i*BYTE_WIDTH +: BYTE_WIDTH]),
            .wren      (lane_wren),
            .wraddress (wraddress),
            .data      (data[i*BYTE_WIDTH +: BYTE_WIDTH])
        );
    end

endmodule

// File: tb/tb_generic_data_bram.sv
// tb/tb_generic_data_bram.sv - scoreboard bench for generic_data_bram
module tb_generic_data_bram;

    localparam int DW = 256;
    localparam int AW = 8;
    localparam int NB = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          aclr;
    logic          rden;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q;
    logic          wren;
    logic [AW-1:0] wraddress;
    logic [DW-1:0] data;
    logic [NB-1:0] byteena_a;

    generic_data_bram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clock     (clock),
        .aclr      (aclr),
        .rden      (rden),
        .rdaddress (rdaddress),
        .q         (q),
        .wren      (wren),
        .wraddress (wraddress),
        .data      (data),
        .byteena_a (byteena_a)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] model_q;
    logic [DW-1:0] exp_fifo [$];
    string         tag_fifo [$];

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [NB-1:0] BE_ALL = '1;
    localparam logic [DW-1:0] PAT    = {4{64'h0123456789ABCDEF}};

    task automatic check_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock edge: drive inputs, predict q, then compare after the edge.
    task automatic drive(input string tag, input logic rst, input logic rd, input logic [AW-1:0] ra,
                         input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] be);
        aclr      = rst;
        rden      = rd;
        rdaddress = ra;
        wren      = wr;
        wraddress = wa;
        data      = wd;
        byteena_a = be;
        if (rst)
            model_q = '0;
        else if (rd)
            model_q = model[ra];
        if (wr)
            for (int i = 0; i < NB; i++)
                if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
        exp_fifo.push_back(model_q);
        tag_fifo.push_back(tag);
        @(posedge clock);
        #1;
        check_vec(tag_fifo.pop_front(), q, exp_fifo.pop_front());
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        logic [DW-1:0] wx;
        logic [DW-1:0] wy;
        logic [DW-1:0] wz;

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_q   = '0;
        aclr      = 1'b1;
        rden      = 1'b0;
        rdaddress = '0;
        wren      = 1'b0;
        wraddress = '0;
        data      = '0;
        byteena_a = '0;

        drive("reset", 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, '0, '0);
        check_vec("reset_q_zero", q, '0);

        drive("powerup_rd_ff", 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, '0, '0);
        check_vec("powerup_ff_zero", q, '0);

        drive("wr5", 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, PAT, BE_ALL);
        drive("rd5", 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, '0, '0);
        check_vec("basic_rd5", q, PAT);

        drive("wr9_aa", 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, {NB{8'hAA}}, BE_ALL);
        drive("wr9_55_mask", 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, {NB{8'h55}}, 32'h0000000F);
        drive("rd9", 1'b0, 1'b1, 8'h09, 1'b0, 8'h00, '0, '0);
        check_vec("bytemask_rd9", q, {{28{8'hAA}}, {4{8'h55}}});

        drive("wr9_nop", 1'b0, 1'b0, 8'h00, 1'b1, 8'h09, '0, '0);
        drive("rd9_after_nop", 1'b0, 1'b1, 8'h09, 1'b0, 8'h00, '0, '0);
        check_vec("zero_mask_noop", q, {{28{8'hAA}}, {4{8'h55}}});

        drive("wr3_11", 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, {NB{8'h11}}, BE_ALL);
        drive("rdw3", 1'b0, 1'b1, 8'h03, 1'b1, 8'h03, {NB{8'h22}}, BE_ALL);
        check_vec("rdw_old_data", q, {NB{8'h11}});
        drive("rd3_new", 1'b0, 1'b1, 8'h03, 1'b0, 8'h00, '0, '0);
        check_vec("rdw_new_next", q, {NB{8'h22}});

        drive("hold_rd5", 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, '0, '0);
        for (int i = 0; i < 4; i++) begin
            drive("hold_idle", 1'b0, 1'b0, 8'h05, 1'b1, 8'h05, '0, BE_ALL);
            check_vec("hold_q", q, PAT);
        end
        drive("rewrite5", 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, PAT, BE_ALL);

        wx = rand_word();
        drive("aclr_with_wr", 1'b1, 1'b1, 8'h05, 1'b1, 8'h40, wx, BE_ALL);
        check_vec("aclr_q_zero", q, '0);
        drive("post_aclr_idle", 1'b0, 1'b0, 8'h05, 1'b0, 8'h00, '0, '0);
        check_vec("post_aclr_hold_zero", q, '0);
        drive("post_aclr_rd5", 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, '0, '0);
        check_vec("contents_survive", q, PAT);
        drive("rd40", 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, '0, '0);
        check_vec("aclr_write_commits", q, wx);

        wy = rand_word();
        wz = rand_word();
        drive("wr20", 1'b0, 1'b0, 8'h00, 1'b1, 8'h20, wy, BE_ALL);
        drive("indep", 1'b0, 1'b1, 8'h20, 1'b1, 8'h10, wz, BE_ALL);
        check_vec("indep_rd20", q, wy);
        drive("rd10", 1'b0, 1'b1, 8'h10, 1'b0, 8'h00, '0, '0);
        check_vec("indep_rd10", q, wz);

        drive("wr_ff", 1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, wx, BE_ALL);
        drive("rd_ff", 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, '0, '0);
        check_vec("top_addr", q, wx);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra;
            logic [AW-1:0] wa;
            logic [NB-1:0] be;
            ra = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            wa = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            be = NB'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) be = BE_ALL;
            drive("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), ra,
                  ($urandom_range(0, 2) != 0), wa, rand_word(), be);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
